// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants shared by the VGA timing generator.
package vga_timing_pkg;

    localparam int POS_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam bit DEF_SYNC_POL = 1'b0;

    function automatic int span_total(int active, int fp, int sync_w, int bp);
        return active + fp + sync_w + bp;
    endfunction

    localparam int DEF_H_TOTAL = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_if.sv
// Raster bundle between the timing generator (master) and pixel-colour logic (slave).
// Carries frame_cnt only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic             ena;
    logic [POS_W-1:0] hpos;
    logic [POS_W-1:0] vpos;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0]       frame_cnt;
`endif

    modport master (
        input  ena,
        output hpos, vpos, hsync, vsync, de, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        output ena,
        input  hpos, vpos, hsync, vsync, de, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
        , input frame_cnt
`endif
    );

endinterface

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-(MAX+1) counter that resets to MAX so the first increment lands on 0.
// value_d exposes the next state so callers can register decodes in step with value.
module wrap_counter #(
    parameter int WIDTH = 10,
    parameter int MAX   = 799
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] value_d,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] value_q;

    always_comb begin
        wrap    = inc && (value_q == MAX_V);
        value_d = value_q;
        if (wrap) begin
            value_d = '0;
        end else if (inc) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= MAX_V;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: position, sync, display-enable and line/frame pulses.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 1024) begin : g_h_total_too_large
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_too_large
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end

    localparam logic [POS_W-1:0] H_ACT_V  = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_ACT_V  = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] HS_START = POS_W'(H_ACTIVE + H_FP);
    localparam logic [POS_W-1:0] HS_END   = POS_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [POS_W-1:0] VS_START = POS_W'(V_ACTIVE + V_FP);
    localparam logic [POS_W-1:0] VS_END   = POS_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [POS_W-1:0] h_q, h_d, v_q, v_d;
    logic             h_wrap, v_wrap;

    wrap_counter #(.WIDTH(POS_W), .MAX(H_TOTAL - 1)) u_hcnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (vga.ena),
        .value   (h_q),
        .value_d (h_d),
        .wrap    (h_wrap)
    );

    // Vertical advances only on the horizontal wrap, so v_wrap marks entry into (0,0).
    wrap_counter #(.WIDTH(POS_W), .MAX(V_TOTAL - 1)) u_vcnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (h_wrap),
        .value   (v_q),
        .value_d (v_d),
        .wrap    (v_wrap)
    );

    logic de_d, de_q;
    logic hsync_d, hsync_q;
    logic vsync_d, vsync_q;
    logic line_start_d, line_start_q;
    logic frame_start_d, frame_start_q;

    // Decoding the next position keeps the registered flags aligned with hpos/vpos.
    always_comb begin
        de_d          = (h_d < H_ACT_V) && (v_d < V_ACT_V);
        hsync_d       = ((h_d >= HS_START) && (h_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = ((v_d >= VS_START) && (v_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q          <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.hpos        = h_q;
    assign vga.vpos        = v_q;
    assign vga.de          = de_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt_d, frame_cnt_q;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing: pixel position, sync and display-enable for the demo's pixel-colour logic, which consumes them directly downstream. Runs one pixel per enabled clock (25.175 MHz nominal, 25.0 MHz acceptable). All outputs are registered and mutually consistent for the same pixel. The top level packs hsync/vsync onto uo_out for the VGA Pmod.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  advance enable; low freezes raster
hpos  out  10  current column, 0..H_TOTAL-1
vpos  out  10  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync at SYNC_POL when active
vsync  out  1  vertical sync at SYNC_POL when active
de  out  1  display enable, high in visible area
line_start  out  1  one-cycle pulse on entry to hpos=0
frame_start  out  1  one-cycle pulse on entry to (0,0)

Behaviour:
- H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Elaboration error if either exceeds 1024.
- Reset (async assert, sync release): hpos=H_TOTAL-1, vpos=V_TOTAL-1, de=0, hsync=vsync=!SYNC_POL, line_start=frame_start=0. First enabled cycle lands on (0,0).
- Each cycle with ena=1: hpos increments; at H_TOTAL-1 it wraps to 0 and vpos increments; vpos wraps from V_TOTAL-1 to 0 when hpos wraps.
- ena=0: hpos/vpos/hsync/vsync/de hold; line_start and frame_start are 0 in the next cycle.
- Outputs are registered from next-state position, so zero latency between hpos/vpos and their decoded signals:
  de = (hpos < H_ACTIVE) && (vpos < V_ACTIVE)
  hsync active for H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC (656..751)
  vsync active for V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC (490..491), whole lines, changes with hpos=0
- line_start = 1 only in the cycle after an advance into hpos=0. frame_start = 1 only in the cycle after an advance into (0,0), so it coincides with a line_start.
- Reset mid-frame returns immediately to the reset state. No partial pulses are emitted.

Optional Feature:
VGA_TIMING_FRAME_CNT_EN. When defined, an extra output frame_cnt [7:0] is added. It resets to 0, increments (mod 256) on each advance into (0,0), holds when ena=0, and is registered alongside frame_start, so it shows the new value in the frame_start cycle. Demo animation uses it. When undefined, the port and its logic are absent and the rest of the behaviour is identical.

Decomposition:
- Package vga_timing_pkg: default timing constants (640/16/96/48, 480/10/2/33), derived H_TOTAL/V_TOTAL, position width constant (10), SYNC_POL default.
- Sub-module wrap_counter (params WIDTH, MAX; inputs inc; outputs value, wrap): instantiated twice, with the horizontal wrap driving the vertical inc.
- Sync/de decode stays inline in vga_timing_gen.

Test Plan:
- Reset with ena=1, release -> first cycle hpos=0, vpos=0, de=1, line_start=1, frame_start=1; next cycle both pulses 0, hpos=1.
- Run one line -> de falls at hpos=640; hsync low for hpos 656..751 (96 cycles); line_start once per 800 cycles.
- Run a full frame -> vsync low exactly on vpos 490..491 (1600 cycles); frame_start period 420000 cycles; de high 307200 cycles per frame.
- Toggle ena low for 5 cycles at hpos=799, vpos=524 -> position frozen, no pulses; on re-enable land on (0,0) with frame_start=1.
- Assert rst_n low mid-line at (300,200) -> outputs immediately at the reset values; after release, restart at (0,0).
- With VGA_TIMING_FRAME_CNT_EN: run 257 frame starts -> frame_cnt reads 1,2,...,255,0,1 in the frame_start cycles.
